btn_conditioner: RTL and testbench

Input-side conditioner for the board push-buttons feeding the LED pattern blocks. It synchronises one raw, bouncy button pin and debounces it in both directions. It outputs a clean level plus single-cycle press, release, long-press and auto-repeat events, and keeps a running press count. The pattern state machines consume these outputs in place of the raw pin.

---
 rtl/btn_conditioner.sv | 155 +++++++++++++++
 tb/tb_btn_conditioner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, two-way debounce FSM,
// single-cycle press/release/long-press/auto-repeat events and a press counter.
module btn_conditioner #(
  parameter int DEBOUNCE   = 16,
  parameter int LONG_PRESS = 1024,
  parameter int REPEAT     = 256,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press,
  output logic       btn_release,
  output logic       long_press,
  output logic       btn_repeat,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(LONG_PRESS + 1);
  localparam int RW = (REPEAT < 1) ? 1 : $clog2(REPEAT + 1);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t        state;
  logic          sync_p0;
  logic          sync_p1;
  logic          s;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;

  // Stage p0/p1: two-flop synchroniser, reset to the not-pressed pin level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= ACTIVE_LOW;
      sync_p1 <= ACTIVE_LOW;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // Normalised sample: 1 always means pressed regardless of pin polarity
  assign s = sync_p1 ^ ACTIVE_LOW;

  // Debounce FSM with registered event pulses, hold/repeat timing and press counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RELEASED;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      btn_level   <= 1'b0;
      press       <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;
      btn_repeat  <= 1'b0;
      press_count <= '0;
    end else begin
      press       <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;
      btn_repeat  <= 1'b0;
      case (state)
        RELEASED: begin
          if (s) begin
            if (DEBOUNCE == 1) begin
              state       <= PRESSED;
              press       <= 1'b1;
              btn_level   <= 1'b1;
              press_count <= press_count + 8'd1;
              hold_cnt    <= '0;
              rep_cnt     <= '0;
              db_cnt      <= '0;
            end else begin
              state  <= PRESS_DB;
              db_cnt <= DW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (!s) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
            // This sample is the DEBOUNCE-th consecutive pressed one
            state       <= PRESSED;
            press       <= 1'b1;
            btn_level   <= 1'b1;
            press_count <= press_count + 8'd1;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            db_cnt      <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        PRESSED: begin
          // Hold timing runs in every PRESSED cycle, including the one that leaves
          if (hold_cnt != HW'(LONG_PRESS)) begin
            hold_cnt <= hold_cnt + HW'(1);
            if (hold_cnt == HW'(LONG_PRESS - 1)) begin
              long_press <= 1'b1;
              rep_cnt    <= '0;
            end
          end else if (REPEAT > 0) begin
            if (rep_cnt == RW'(REPEAT - 1)) begin
              btn_repeat <= 1'b1;
              rep_cnt    <= '0;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
          if (!s) begin
            if (DEBOUNCE == 1) begin
              state       <= RELEASED;
              btn_release <= 1'b1;
              btn_level   <= 1'b0;
              db_cnt      <= '0;
            end else begin
              state  <= RELEASE_DB;
              db_cnt <= DW'(1);
            end
          end
        end
        RELEASE_DB: begin
          // Hold and repeat counters stay frozen while a release is being qualified
          if (s) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
            state       <= RELEASED;
            btn_release <= 1'b1;
            btn_level   <= 1'b0;
            db_cnt      <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        default: begin
          state  <= RELEASED;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed stimulus pushes expected
// events with absolute cycle numbers; per-instance monitors compare them.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int LP = 20;
  localparam int RP = 5;

  typedef struct {
    int   cyc;
    int   kind;   // 0 press, 1 release, 2 long_press, 3 repeat
    int   cnt;
    logic lvl;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn_n;
  int   cyc = 0;

  logic       lvl0, prs0, rel0, lp0, rp0;
  logic [7:0] cnt0;
  logic       lvl1, prs1, rel1, lp1, rp1;
  logic [7:0] cnt1;

  ev_t exp_q[$];
  int  rd[2];
  int  total = 0;
  int  fails = 0;
  int  exp_cnt = 0;

  assign btn_n = ~btn;

  btn_conditioner #(.DEBOUNCE(DB), .LONG_PRESS(LP), .REPEAT(RP), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn), .btn_level(lvl0), .press(prs0),
    .btn_release(rel0), .long_press(lp0), .btn_repeat(rp0), .press_count(cnt0)
  );

  btn_conditioner #(.DEBOUNCE(DB), .LONG_PRESS(LP), .REPEAT(RP), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .btn_in(btn_n), .btn_level(lvl1), .press(prs1),
    .btn_release(rel1), .long_press(lp1), .btn_repeat(rp1), .press_count(cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int cy, input int k, input int cn, input logic l);
    ev_t e;
    e.cyc = cy; e.kind = k; e.cnt = cn; e.lvl = l;
    exp_q.push_back(e);
  endtask

  task automatic mon(input int idx, input logic [3:0] ev, input logic lvl, input logic [7:0] cnt);
    ev_t e;
    while (rd[idx] < exp_q.size() && exp_q[rd[idx]].cyc < cyc) begin
      chk($sformatf("missed_kind%0d_at%0d_i%0d", exp_q[rd[idx]].kind, exp_q[rd[idx]].cyc, idx), 0, 1);
      rd[idx]++;
    end
    if (ev != 4'b0000) begin
      if (rd[idx] >= exp_q.size()) begin
        chk($sformatf("unexpected_event_i%0d", idx), 32'(ev), 0);
      end else begin
        e = exp_q[rd[idx]];
        rd[idx]++;
        chk($sformatf("event_kind_i%0d", idx), 32'(ev), 32'(4'b0001 << e.kind));
        chk($sformatf("event_cycle_i%0d", idx), cyc, e.cyc);
        chk($sformatf("event_count_i%0d", idx), 32'(cnt), e.cnt);
        chk($sformatf("event_level_i%0d", idx), 32'(lvl), 32'(e.lvl));
      end
    end
  endtask

  // Monitors: one per instance, both checked against the same expectations
  always @(negedge clk) begin
    if (cyc > 0) begin
      mon(0, {rp0, lp0, rel0, prs0}, lvl0, cnt0);
      mon(1, {rp1, lp1, rel1, prs1}, lvl1, cnt1);
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_i0"}, {19'd0, lvl0, prs0, rel0, lp0, rp0, cnt0}, 0);
    chk({name, "_i1"}, {19'd0, lvl1, prs1, rel1, lp1, rp1, cnt1}, 0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_lvl_i0"}, 32'(lvl0), 0);
    chk({name, "_cnt_i0"}, 32'(cnt0), 32'(exp_cnt % 256));
    chk({name, "_lvl_i1"}, 32'(lvl1), 0);
    chk({name, "_cnt_i1"}, 32'(cnt1), 32'(exp_cnt % 256));
  endtask

  // Press at negedge c: press seen at c+6, release (driven at c+hold) at c+hold+6
  task automatic press_release(input int hold);
    int c;
    @(negedge clk);
    btn = 1'b1;
    c = cyc;
    exp_cnt++;
    push(c + 6, 0, exp_cnt % 256, 1'b1);
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    push(c + hold + 6, 1, exp_cnt % 256, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int c;
    int r;
    rd[0] = 0;
    rd[1] = 0;

    // Reset with the pin toggling
    repeat (3) begin
      @(negedge clk);
      btn = ~btn;
      chk_zero("reset_outputs");
    end
    @(negedge clk);
    rst = 1'b0;
    btn = 1'b0;
    repeat (6) @(negedge clk);
    chk_idle("after_reset");

    // Clean press and release
    press_release(15);
    chk_idle("after_clean");

    // Bounce shorter than the debounce window
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    chk_idle("after_bounce");

    // Long hold: long_press at P+20, repeats at P+25..P+50
    @(negedge clk);
    btn = 1'b1;
    c = cyc;
    exp_cnt++;
    push(c + 6, 0, exp_cnt, 1'b1);
    push(c + 26, 2, exp_cnt, 1'b1);
    for (int k = 0; k < 6; k++) push(c + 31 + 5 * k, 3, exp_cnt, 1'b1);
    repeat (56) @(negedge clk);
    btn = 1'b0;
    push(c + 62, 1, exp_cnt, 1'b0);
    repeat (10) @(negedge clk);

    // Two-cycle release glitch during a hold delays long_press to P+22
    @(negedge clk);
    btn = 1'b1;
    c = cyc;
    exp_cnt++;
    push(c + 6, 0, exp_cnt, 1'b1);
    push(c + 28, 2, exp_cnt, 1'b1);
    repeat (15) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1;
    repeat (12) @(negedge clk);
    btn = 1'b0;
    push(c + 35, 1, exp_cnt, 1'b0);
    repeat (10) @(negedge clk);
    chk_idle("after_glitch");

    // 256 presses: counter passes 255 and wraps to 0
    for (int n = 0; n < 256; n++) press_release(10);
    chk_idle("after_wrap");

    // Reset in the middle of a hold, then a fresh press while still held
    @(negedge clk);
    btn = 1'b1;
    c = cyc;
    exp_cnt++;
    push(c + 6, 0, exp_cnt % 256, 1'b1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midhold_reset_a");
    @(negedge clk);
    chk_zero("midhold_reset_b");
    rst = 1'b0;
    r = cyc;
    exp_cnt = 1;
    push(r + 6, 0, 1, 1'b1);
    repeat (10) @(negedge clk);
    btn = 1'b0;
    push(cyc + 6, 1, 1, 1'b0);
    repeat (20) @(negedge clk);
    chk_idle("final_idle");

    chk("all_events_seen_i0", rd[0], exp_q.size());
    chk("all_events_seen_i1", rd[1], exp_q.size());

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
